avalon_to_ahb_lite_bridge: RTL

//  Avalon-MM slave to AHB-Lite master bridge. Sits directly upstream of the AHB slave.

---
 rtl/avalon_to_ahb_lite_bridge.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/avalon_to_ahb_lite_bridge.sv
// ---------------------------------------------------------------------------
// avalon_to_ahb_lite_bridge
//
// Avalon-MM slave to AHB-Lite master bridge. Each Avalon read or write is
// turned into one SINGLE/NONSEQ AHB-Lite transfer, one outstanding at a time.
// Read data and the AHB response are returned on the Avalon side.
//
// Optional feature macro: AHB_BRIDGE_TIMEOUT_EN
//   defined   : the data phase is abandoned after TIMEOUT_CYCLES HREADY-low
//               cycles (response DECODEERROR, readdata 0), then the bridge
//               drains the stuck transfer before accepting new work.
//   undefined : the data phase waits for HREADY indefinitely.
//
// Parameters
//   ADDR_W          byte-address width on both sides
//   TIMEOUT_CYCLES  HREADY-low limit in the data phase (timeout build only)
//
// Ports
//   clk_clk, reset_reset          single clock, synchronous active-high reset
//   avs_address/read/write        Avalon command (held stable by the master)
//   avs_byteenable/writedata      Avalon lane enables and write data
//   avs_readdata/response         completion data and status
//   avs_waitrequest               low for exactly one cycle per completion
//   ahb_haddr/htrans/hwrite       AHB address phase
//   ahb_hsize/hburst/hwdata       AHB transfer size, burst (SINGLE), wdata
//   ahb_hrdata/hready/hresp       AHB slave data-phase response
//
// Timeline for a zero-wait slave (one cycle per state):
//   IDLE (command seen) -> ADDR (NONSEQ) -> DATA -> DONE (waitrequest low)
// ---------------------------------------------------------------------------
module avalon_to_ahb_lite_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [3:0]        avs_byteenable,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [1:0]        avs_response,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ahb_haddr,
    output logic [1:0]        ahb_htrans,
    output logic              ahb_hwrite,
    output logic [2:0]        ahb_hsize,
    output logic [2:0]        ahb_hburst,
    output logic [31:0]       ahb_hwdata,
    input  logic [31:0]       ahb_hrdata,
    input  logic              ahb_hready,
    input  logic              ahb_hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AHB_BRIDGE_TIMEOUT_EN
    localparam logic [1:0] RESP_DECERR = 2'b11;
`endif

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd3
`ifdef AHB_BRIDGE_TIMEOUT_EN
        ,
        ST_DRAIN = 3'd4
`endif
    } state_t;

    // -----------------------------------------------------------------------
    // Byteenable decode: only naturally aligned byte/half/word lane patterns
    // map onto an AHB transfer; everything else is rejected locally.
    // -----------------------------------------------------------------------
    logic       be_legal;
    logic [2:0] be_size;
    logic [1:0] be_offset;

    always_comb begin
        be_legal  = 1'b1;
        be_size   = HSIZE_BYTE;
        be_offset = 2'b00;
        case (avs_byteenable)
            4'b1111: be_size = HSIZE_WORD;
            4'b0011: be_size = HSIZE_HALF;
            4'b1100: begin be_size = HSIZE_HALF; be_offset = 2'b10; end
            4'b0001: be_offset = 2'b00;
            4'b0010: be_offset = 2'b01;
            4'b0100: be_offset = 2'b10;
            4'b1000: be_offset = 2'b11;
            default: be_legal = 1'b0;
        endcase
    end

    // Low address bits are replaced by the lane offset from the decode.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^avs_address[1:0];

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    state_t            state_q,       state_d;
    logic              waitrequest_q, waitrequest_d;
    logic [1:0]        htrans_q,      htrans_d;
    logic [ADDR_W-1:0] haddr_q,       haddr_d;
    logic              hwrite_q,      hwrite_d;
    logic [2:0]        hsize_q,       hsize_d;
    logic [31:0]       hwdata_q,      hwdata_d;
    logic [31:0]       readdata_q,    readdata_d;
    logic [1:0]        response_q,    response_d;

`ifdef AHB_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q,   tmo_cnt_d;
    // Set when DONE was reached by timeout: the AHB transfer is still open.
    logic             timed_out_q, timed_out_d;
`else
    // Without the timeout feature this parameter has no effect.
    localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d       = state_q;
        waitrequest_d = 1'b1;
        htrans_d      = HTRANS_IDLE;
        haddr_d       = haddr_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        hwdata_d      = hwdata_q;
        readdata_d    = readdata_q;
        response_d    = response_q;
`ifdef AHB_BRIDGE_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timed_out_d   = timed_out_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (avs_read || avs_write) begin
                    if (be_legal) begin
                        // read wins when both strobes are high
                        haddr_d  = {avs_address[ADDR_W-1:2], be_offset};
                        hwrite_d = ~avs_read;
                        hsize_d  = be_size;
                        if (!avs_read) begin
                            hwdata_d = avs_writedata;
                        end
                        htrans_d = HTRANS_NONSEQ;
                        state_d  = ST_ADDR;
                    end else begin
                        // never reaches the bus: complete locally as SLVERR
                        response_d    = RESP_SLVERR;
                        waitrequest_d = 1'b0;
                        state_d       = ST_DONE;
                    end
                end
            end

            // Sole master on the bus, so HREADY is not checked here.
            ST_ADDR: begin
                state_d = ST_DATA;
`ifdef AHB_BRIDGE_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            ST_DATA: begin
                // A two-cycle ERROR completes on its HREADY-high cycle, where
                // HRESP is still high, so sampling only on HREADY suffices.
                if (ahb_hready) begin
                    if (!hwrite_q) begin
                        readdata_d = ahb_hrdata;
                    end
                    response_d    = ahb_hresp ? RESP_SLVERR : RESP_OKAY;
                    waitrequest_d = 1'b0;
                    state_d       = ST_DONE;
                end
`ifdef AHB_BRIDGE_TIMEOUT_EN
                else if (tmo_cnt_q == CNT_LAST) begin
                    response_d    = RESP_DECERR;
                    readdata_d    = '0;
                    waitrequest_d = 1'b0;
                    timed_out_d   = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_DONE: begin
`ifdef AHB_BRIDGE_TIMEOUT_EN
                // If the stuck slave already released HREADY during DONE,
                // there is nothing left to drain.
                if (timed_out_q && !ahb_hready) begin
                    state_d = ST_DRAIN;
                end else begin
                    timed_out_d = 1'b0;
                    state_d     = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end

`ifdef AHB_BRIDGE_TIMEOUT_EN
            // Abandoned transfer still owns the data phase; keep new
            // commands stalled until the slave finally signals HREADY.
            ST_DRAIN: begin
                if (ahb_hready) begin
                    timed_out_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q       <= ST_IDLE;
            waitrequest_q <= 1'b1;
            htrans_q      <= HTRANS_IDLE;
            haddr_q       <= '0;
            hwrite_q      <= 1'b0;
            hsize_q       <= 3'b000;
            hwdata_q      <= '0;
            readdata_q    <= '0;
            response_q    <= RESP_OKAY;
`ifdef AHB_BRIDGE_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timed_out_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            waitrequest_q <= waitrequest_d;
            htrans_q      <= htrans_d;
            haddr_q       <= haddr_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            hwdata_q      <= hwdata_d;
            readdata_q    <= readdata_d;
            response_q    <= response_d;
`ifdef AHB_BRIDGE_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timed_out_q   <= timed_out_d;
`endif
        end
    end

    assign avs_waitrequest = waitrequest_q;
    assign avs_readdata    = readdata_q;
    assign avs_response    = response_q;
    assign ahb_htrans      = htrans_q;
    assign ahb_haddr       = haddr_q;
    assign ahb_hwrite      = hwrite_q;
    assign ahb_hsize       = hsize_q;
    assign ahb_hwdata      = hwdata_q;
    assign ahb_hburst      = 3'b000;

endmodule
